keypad_scanner: RTL and testbench

- Upstream front end of the calculator datapath.
- Scans a 4x4 active-low key matrix and debounces key presses at frame level.
- Encodes each accepted press into the strobes the operand/operator sequencer consumes: digit plus read_input, a held operator code, equal_input and clear.
- Emits exactly one event per physical press, regardless of hold time or contact bounce.

---
 rtl/keypad_scanner.sv | 224 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: front end of the calculator datapath.
// Scans a 4x4 active-low key matrix one row at a time. The result of each
// full frame is debounced, and every accepted press is turned into the
// strobes that the operand/operator sequencer consumes.
// Ports:
//   clk, nRST        clock; asynchronous active-low reset
//   col_n[3:0]       matrix columns (active-low, asynchronous to clk)
//   row_n[3:0]       row drives, one-hot-low
//   keypad_input     last accepted digit, held
//   read_input       one-cycle pulse for each digit press
//   operator_input   held operator code (001 add, 010 sub, 100 mul)
//   equal_input      one-cycle pulse for '='
//   clear            one-cycle pulse for 'C'; also clears digit and operator
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input,
  output logic       clear
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB     = 4'(DEBOUNCE_CNT);
  localparam logic [3:0] K_ADD  = 4'd10;
  localparam logic [3:0] K_SUB  = 4'd11;
  localparam logic [3:0] K_MUL  = 4'd12;
  localparam logic [3:0] K_EQ   = 4'd13;
  localparam logic [3:0] K_CLR  = 4'd14;
  localparam logic [3:0] K_NONE = 4'd15;

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

  // Internal key codes: digits are their own value, the rest sit at 10..14.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;
      4'h2: key_code = 4'd3;   4'h3: key_code = K_ADD;
      4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;
      4'h6: key_code = 4'd6;   4'h7: key_code = K_SUB;
      4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;
      4'hA: key_code = 4'd9;   4'hB: key_code = K_MUL;
      4'hC: key_code = K_CLR;  4'hD: key_code = 4'd0;
      4'hE: key_code = K_EQ;
      default: key_code = K_NONE;
    endcase
  endfunction

  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    row_idx;
  logic          sample, frame_end;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      dwell   <= '0;
      row_idx <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (dwell == DWELL_LAST) begin
        dwell   <= '0;
        row_idx <= row_idx + 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign row_n     = ~(4'b0001 << row_idx);
  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (row_idx == 2'd3);

  // Keys seen in the current row; the fourth key of row 3 is not a key.
  logic [3:0] row_hits;
  logic [2:0] row_num;
  logic [3:0] row_code;
  always_comb begin
    row_hits = ~col_s2;
    if (row_idx == 2'd3) row_hits[3] = 1'b0;
    row_num  = '0;
    row_code = K_NONE;
    for (int c = 0; c < 4; c++) begin
      if (row_hits[c]) begin
        row_num  = row_num + 3'd1;
        row_code = key_code(row_idx, 2'(c));
      end
    end
  end

  // Frame accumulator: key count saturates at 2 (= MULTI); row 0 starts afresh.
  logic [1:0] acc_num, base_num, frm_num;
  logic [3:0] acc_code, base_code, frm_code;
  logic [2:0] sum;
  logic       frm_none, frm_key;
  always_comb begin
    base_num  = (row_idx == 2'd0) ? 2'd0 : acc_num;
    base_code = acc_code;
    sum       = {1'b0, base_num} + row_num;
    frm_num   = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frm_code  = (base_num == 2'd0) ? row_code : base_code;
    frm_none  = (frm_num == 2'd0);
    frm_key   = (frm_num == 2'd1);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      acc_num  <= '0;
      acc_code <= K_NONE;
    end else if (sample) begin
      acc_num  <= frm_num;
      acc_code <= frm_code;
    end
  end

  // Debounce FSM, advanced only on frame end.
  state_t     state, nxt_state;
  logic [3:0] cnt, nxt_cnt, cand, nxt_cand;
  logic       fire;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= K_NONE;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      cand  <= nxt_cand;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_cand  = cand;
    fire      = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: if (frm_key) begin
          nxt_cand = frm_code;
          if (DEBOUNCE_CNT == 1) begin
            nxt_state = PRESSED;
            nxt_cnt   = '0;
            fire      = 1'b1;
          end else begin
            nxt_state = CAND;
            nxt_cnt   = 4'd1;
          end
        end
        CAND: if (frm_key && frm_code == cand) begin
          if (cnt + 4'd1 == DB) begin
            nxt_state = PRESSED;
            nxt_cnt   = '0;
            fire      = 1'b1;
          end else begin
            nxt_cnt = cnt + 4'd1;
          end
        end else begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
        PRESSED: if (frm_none) begin
          if (DEBOUNCE_CNT == 1) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_state = RELEASE;
            nxt_cnt   = 4'd1;
          end
        end
        RELEASE: if (frm_none) begin
          if (cnt + 4'd1 == DB) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 4'd1;
          end
        end else begin
          // MULTI counts as a key here: the press is still going on.
          nxt_state = PRESSED;
          nxt_cnt   = '0;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // fire only happens when frm_code is the accepted key, so it names the event.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      keypad_input   <= '0;
      read_input     <= 1'b0;
      operator_input <= '0;
      equal_input    <= 1'b0;
      clear          <= 1'b0;
    end else begin
      read_input  <= fire && (frm_code <= 4'd9);
      equal_input <= fire && (frm_code == K_EQ);
      clear       <= fire && (frm_code == K_CLR);
      if (fire) begin
        case (frm_code)
          K_ADD: operator_input <= 3'b001;
          K_SUB: operator_input <= 3'b010;
          K_MUL: operator_input <= 3'b100;
          K_EQ:  ;
          K_CLR: begin
            operator_input <= 3'b000;
            keypad_input   <= 4'd0;
          end
          default: keypad_input <= frm_code;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=2
// (16-cycle frames). A behavioural key matrix pulls a column low while the
// row of a held key is driven low.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       clear;

  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk(clk), .nRST(nRST), .col_n(col_n), .row_n(row_n),
    .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input), .clear(clear)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  localparam int KEY_1 = 0, KEY_2 = 1, KEY_3 = 2, KEY_ADD = 3;
  localparam int KEY_4 = 4, KEY_5 = 5, KEY_6 = 6;
  localparam int KEY_7 = 8, KEY_9 = 10, KEY_MUL = 11;
  localparam int KEY_C = 12, KEY_EQ = 14;

  int total = 0, bad = 0;
  int cyc;
  int rd_total = 0, eq_total = 0, clr_total = 0, viol = 0;
  int rd_cyc = -1;
  logic [3:0] rd_digit = '0;
  logic [2:0] eq_op = '0;
  bit prev_pulse = 0;

  always @(posedge clk or negedge nRST)
    if (!nRST) cyc <= 0;
    else       cyc <= cyc + 1;

  // Event monitor: counts pulses and flags overlap / back-to-back pulses.
  always @(negedge clk) begin
    int n;
    if (nRST) begin
      n = int'(read_input) + int'(equal_input) + int'(clear);
      if (read_input) begin rd_total++; rd_digit = keypad_input; rd_cyc = cyc; end
      if (equal_input) begin eq_total++; eq_op = operator_input; end
      if (clear) clr_total++;
      if (n > 1) viol++;
      if (n > 0 && prev_pulse) viol++;
      prev_pulse = (n > 0);
    end else begin
      prev_pulse = 0;
    end
  end

  task automatic frames(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 16 && (cyc % 16) != 0; i++) @(negedge clk);
  endtask

  task automatic press(input int k, input int on_f, input int off_f);
    align();
    keys = '0;
    keys[k] = 1'b1;
    frames(on_f);
    keys = '0;
    frames(off_f);
  endtask

  task automatic check_reset_outputs(input string tag);
    if ({row_n, keypad_input, read_input, operator_input, equal_input, clear} !== {4'b1110, 4'd0, 1'b0, 3'b000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s: row_n=%b key=%0d rd=%b op=%b eq=%b clr=%b, expected 1110/0/0/000/0/0",
               tag, row_n, keypad_input, read_input, operator_input, equal_input, clear);
    end
    total++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
  endtask

  task automatic test_hold7();
    int r0;
    logic [3:0] exp_row;
    keys = '0;
    keys[KEY_7] = 1'b1;
    nRST = 1'b1;           // released at a negedge: cyc 0 is the first row-0 cycle
    r0 = rd_total;
    for (int i = 0; i < 16; i++) begin
      exp_row = 4'b1111 ^ (4'b0001 << (i / 4));
      if (row_n !== exp_row) begin
        bad++;
        $display("FAIL row_scan[%0d]: row_n=%b expected %b", i, row_n, exp_row);
      end
      total++;
      @(negedge clk);
    end
    frames(9);
    if (rd_total - r0 !== 1) begin
      bad++; $display("FAIL hold7_count: got %0d expected 1", rd_total - r0);
    end
    total++;
    if (rd_digit !== 4'd7) begin
      bad++; $display("FAIL hold7_digit: got %0d expected 7", rd_digit);
    end
    total++;
    // frame ends are sampled at cycles 15 and 31; the pulse follows the second
    if (rd_cyc !== 32) begin
      bad++; $display("FAIL hold7_latency: pulse at cycle %0d expected 32", rd_cyc);
    end
    total++;
    keys = '0;
    frames(4);
    if (keypad_input !== 4'd7) begin
      bad++; $display("FAIL hold7_held: keypad_input=%0d expected 7", keypad_input);
    end
    total++;
  endtask

  task automatic test_bounce5();
    int r0, t0;
    align();
    t0 = cyc;
    r0 = rd_total;
    keys = '0; keys[KEY_5] = 1'b1; frames(1);
    keys = '0;                     frames(1);
    keys[KEY_5] = 1'b1;            frames(3);
    keys = '0;                     frames(4);
    if (rd_total - r0 !== 1) begin
      bad++; $display("FAIL bounce_count: got %0d expected 1", rd_total - r0);
    end
    total++;
    if (rd_digit !== 4'd5) begin
      bad++; $display("FAIL bounce_digit: got %0d expected 5", rd_digit);
    end
    total++;
    if (rd_cyc !== t0 + 64) begin
      bad++; $display("FAIL bounce_latency: pulse at cycle %0d expected %0d", rd_cyc, t0 + 64);
    end
    total++;
  endtask

  task automatic test_sequence();
    int r0, e0, c0;
    r0 = rd_total; e0 = eq_total; c0 = clr_total;
    press(KEY_1, 3, 3);
    if (rd_total - r0 !== 1 || rd_digit !== 4'd1) begin
      bad++; $display("FAIL seq_digit1: count=%0d digit=%0d expected 1/1", rd_total - r0, rd_digit);
    end
    total++;
    press(KEY_ADD, 3, 3);
    if (operator_input !== 3'b001) begin
      bad++; $display("FAIL seq_add: operator_input=%b expected 001", operator_input);
    end
    total++;
    press(KEY_2, 3, 3);
    if (rd_total - r0 !== 2 || keypad_input !== 4'd2) begin
      bad++; $display("FAIL seq_digit2: count=%0d key=%0d expected 2/2", rd_total - r0, keypad_input);
    end
    total++;
    press(KEY_EQ, 3, 3);
    if (eq_total - e0 !== 1 || eq_op !== 3'b001 || operator_input !== 3'b001) begin
      bad++; $display("FAIL seq_equal: count=%0d op_at_pulse=%b op=%b expected 1/001/001",
                      eq_total - e0, eq_op, operator_input);
    end
    total++;
    press(KEY_C, 3, 3);
    if (clr_total - c0 !== 1 || operator_input !== 3'b000 || keypad_input !== 4'd0) begin
      bad++; $display("FAIL seq_clear: count=%0d op=%b key=%0d expected 1/000/0",
                      clr_total - c0, operator_input, keypad_input);
    end
    total++;
  endtask

  task automatic test_multi();
    int r0, e0, c0;
    logic [2:0] op0;
    r0 = rd_total; e0 = eq_total; c0 = clr_total; op0 = operator_input;
    align();
    keys = '0; keys[KEY_3] = 1'b1; keys[KEY_6] = 1'b1;
    frames(6);
    if (rd_total - r0 + eq_total - e0 + clr_total - c0 !== 0 || operator_input !== op0) begin
      bad++; $display("FAIL multi_silent: events=%0d op=%b expected 0/%b",
                      rd_total - r0 + eq_total - e0 + clr_total - c0, operator_input, op0);
    end
    total++;
    keys[KEY_6] = 1'b0;
    frames(3);
    keys = '0;
    frames(3);
    if (rd_total - r0 !== 1 || rd_digit !== 4'd3) begin
      bad++; $display("FAIL multi_release6: count=%0d digit=%0d expected 1/3", rd_total - r0, rd_digit);
    end
    total++;
  endtask

  task automatic test_rebounce();
    int r0;
    // operator: one event despite a single-frame release gap
    press(KEY_MUL, 3, 1);
    keys[KEY_MUL] = 1'b1; frames(5);
    keys = '0;            frames(4);
    if (operator_input !== 3'b100) begin
      bad++; $display("FAIL rebounce_mul: operator_input=%b expected 100", operator_input);
    end
    total++;
    // same gap on a digit, where a second event would be visible
    r0 = rd_total;
    press(KEY_4, 3, 1);
    keys[KEY_4] = 1'b1; frames(5);
    keys = '0;          frames(4);
    if (rd_total - r0 !== 1 || rd_digit !== 4'd4) begin
      bad++; $display("FAIL rebounce_digit: count=%0d digit=%0d expected 1/4", rd_total - r0, rd_digit);
    end
    total++;
  endtask

  task automatic test_reset_mid_hold();
    int r0;
    align();
    keys = '0; keys[KEY_9] = 1'b1;
    frames(3);
    repeat (5) @(negedge clk);    // get off row 0 so the reset row value means something
    if (keypad_input !== 4'd9) begin
      bad++; $display("FAIL midreset_pre: keypad_input=%0d expected 9", keypad_input);
    end
    total++;
    nRST = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    r0 = rd_total;
    frames(3);
    if (rd_total - r0 !== 1 || rd_digit !== 4'd9 || rd_cyc !== 32) begin
      bad++; $display("FAIL midreset_reaccept: count=%0d digit=%0d cycle=%0d expected 1/9/32",
                      rd_total - r0, rd_digit, rd_cyc);
    end
    total++;
    keys = '0;
    frames(4);
  endtask

  task automatic test_exclusive();
    if (viol !== 0) begin
      bad++; $display("FAIL pulse_spacing: violations=%0d expected 0", viol);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_hold7();
    test_bounce5();
    test_sequence();
    test_multi();
    test_rebounce();
    test_reset_mid_hold();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
